// File: rtl/stream_sobel_edge_detector_if.sv
// Pixel-in / magnitude-out stream bundle for the Sobel edge detector.
// slave = detector side, master = producer/consumer environment side. DIRECTION_OUT_EN adds m_dir.
interface stream_sobel_edge_detector_if #(
    parameter int PIXEL_W = 8
);
    localparam int MAG_W = PIXEL_W + 3;

    logic               s_valid;
    logic               s_ready;
    logic [PIXEL_W-1:0] s_pixel;
    logic               m_valid;
    logic               m_ready;
    logic [MAG_W-1:0]   m_mag;
    logic               m_edge;
    logic               m_last;
`ifdef DIRECTION_OUT_EN
    logic [1:0]         m_dir;

    modport slave  (input  s_valid, s_pixel, m_ready,
                    output s_ready, m_valid, m_mag, m_edge, m_last, m_dir);
    modport master (output s_valid, s_pixel, m_ready,
                    input  s_ready, m_valid, m_mag, m_edge, m_last, m_dir);
`else
    modport slave  (input  s_valid, s_pixel, m_ready,
                    output s_ready, m_valid, m_mag, m_edge, m_last);
    modport master (output s_valid, s_pixel, m_ready,
                    input  s_ready, m_valid, m_mag, m_edge, m_last);
`endif
endinterface

// File: rtl/stream_sobel_edge_detector.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 window and a single output register.
// Optional macro DIRECTION_OUT_EN adds a quantised gradient direction (m_dir) alongside m_mag.
module stream_sobel_edge_detector #(
    parameter int IMAGE_WIDTH  = 400,
    parameter int IMAGE_HEIGHT = 500,
    parameter int PIXEL_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [PIXEL_W+2:0]         threshold,
    stream_sobel_edge_detector_if.slave bus,
    output logic                       frame_done
);
    localparam int MAG_W = PIXEL_W + 3;
    localparam int GW    = PIXEL_W + 4;
    localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int FL_W  = $clog2(IMAGE_WIDTH + 2);

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [COL_W-1:0] in_col_q, in_col_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [MAG_W-1:0] thr_q, thr_d;
    logic             m_valid_q, m_valid_d;
    logic [MAG_W-1:0] m_mag_q, m_mag_d;
    logic             m_edge_q, m_edge_d;
    logic             m_last_q, m_last_d;
    logic             frame_done_q, frame_done_d;
`ifdef DIRECTION_OUT_EN
    logic [1:0]       m_dir_q, m_dir_d;
    logic [1:0]       dir;
    logic [GW+2:0]    ax5, ay5, ax2, ay2;
`endif

    logic stall, s_ready, accept, produce, border, last_pos;

    assign stall   = m_valid_q && !bus.m_ready;
    assign s_ready = enable && ((state_q == FILL) || (state_q == RUN)) && !stall;
    assign accept  = bus.s_valid && s_ready;

    // Line buffers hold the previous two rows, addressed by input column.
    logic [PIXEL_W-1:0] lb1_mem [IMAGE_WIDTH];
    logic [PIXEL_W-1:0] lb2_mem [IMAGE_WIDTH];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[in_col_q] <= bus.s_pixel;
            lb2_mem[in_col_q] <= lb1_mem[in_col_q];
        end
    end

    // Column entering the window: [0]=two rows up, [1]=one row up, [2]=current pixel.
    logic [2:0][PIXEL_W-1:0]      col_in;
    logic [2:0][2:0][PIXEL_W-1:0] win;
    assign col_in = {bus.s_pixel, lb1_mem[in_col_q], lb2_mem[in_col_q]};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win
            logic [2:0][PIXEL_W-1:0] tap_q, tap_d;
            always_comb begin
                tap_d = tap_q;
                if (accept) tap_d = {col_in[gi], tap_q[2:1]};
            end
            always_ff @(posedge clk) tap_q <= tap_d;
            // The window seen by the output stage already contains the pixel being accepted.
            assign win[gi] = tap_d;
        end
    endgenerate

    function automatic logic signed [GW-1:0] ext(input logic [PIXEL_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        ax, ay;
    logic [MAG_W-1:0]     mag;

    always_comb begin
        gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
        ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag = MAG_W'(ax + ay);
    end

`ifdef DIRECTION_OUT_EN
    always_comb begin
        ax2 = {3'b000, ax} << 1;
        ay2 = {3'b000, ay} << 1;
        ax5 = ({3'b000, ax} << 2) + {3'b000, ax};
        ay5 = ({3'b000, ay} << 2) + {3'b000, ay};
        if (ay5 < ax2)                 dir = 2'd0;
        else if (ax5 < ay2)            dir = 2'd2;
        else if (gx[GW-1] == gy[GW-1]) dir = 2'd1;
        else                           dir = 2'd3;
    end
`endif

    assign border   = (out_row_q == '0) || (out_row_q == ROW_W'(IMAGE_HEIGHT - 1)) ||
                      (out_col_q == '0) || (out_col_q == COL_W'(IMAGE_WIDTH - 1));
    assign last_pos = (out_row_q == ROW_W'(IMAGE_HEIGHT - 1)) &&
                      (out_col_q == COL_W'(IMAGE_WIDTH - 1));

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        in_col_d     = in_col_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        flush_cnt_d  = flush_cnt_q;
        thr_d        = thr_q;
        m_valid_d    = m_valid_q;
        m_mag_d      = m_mag_q;
        m_edge_d     = m_edge_q;
        m_last_d     = m_last_q;
        frame_done_d = 1'b0;
        produce      = 1'b0;
`ifdef DIRECTION_OUT_EN
        m_dir_d      = m_dir_q;
`endif
        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    thr_d   = threshold;
                    state_d = FILL;
                end
            end
            FILL, RUN: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    in_col_d = (in_col_q == COL_W'(IMAGE_WIDTH - 1)) ? '0 : in_col_q + 1'b1;
                    if (state_q == RUN) produce = 1'b1;
                    if ((state_q == FILL) && (in_cnt_q == CNT_W'(IMAGE_WIDTH))) state_d = RUN;
                    if ((state_q == RUN) && (in_cnt_q == CNT_W'(NPIX - 1)))    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Remaining outputs all lie on the bottom/right border, so no input is needed.
                if (enable && !stall && (flush_cnt_q != FL_W'(IMAGE_WIDTH + 1))) begin
                    produce     = 1'b1;
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
                if (m_valid_q && bus.m_ready && m_last_q) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                in_cnt_d    = '0;
                in_col_d    = '0;
                out_col_d   = '0;
                out_row_d   = '0;
                flush_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase

        if (produce) begin
            m_valid_d = 1'b1;
            m_last_d  = last_pos;
            m_mag_d   = border ? '0 : mag;
            m_edge_d  = !border && (mag >= thr_q);
`ifdef DIRECTION_OUT_EN
            m_dir_d   = border ? 2'd0 : dir;
`endif
            if (out_col_q == COL_W'(IMAGE_WIDTH - 1)) begin
                out_col_d = '0;
                out_row_d = out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            in_cnt_q     <= '0;
            in_col_q     <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            flush_cnt_q  <= '0;
            thr_q        <= '0;
            m_valid_q    <= 1'b0;
            m_mag_q      <= '0;
            m_edge_q     <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef DIRECTION_OUT_EN
            m_dir_q      <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            in_col_q     <= in_col_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            flush_cnt_q  <= flush_cnt_d;
            thr_q        <= thr_d;
            m_valid_q    <= m_valid_d;
            m_mag_q      <= m_mag_d;
            m_edge_q     <= m_edge_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
`ifdef DIRECTION_OUT_EN
            m_dir_q      <= m_dir_d;
`endif
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_mag   = m_mag_q;
    assign bus.m_edge  = m_edge_q;
    assign bus.m_last  = m_last_q;
`ifdef DIRECTION_OUT_EN
    assign bus.m_dir   = m_dir_q;
`endif
    assign frame_done  = frame_done_q;

endmodule
